// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: ALU op and funct encodings, the MDU FSM state
// and the EX/MEM pipeline-register bundle.
package mips_pkg;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluSub   = 2'b01,
    AluRtype = 2'b10,
    AluRsvd  = 2'b11
  } alu_op_e;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;

  typedef enum logic {
    StIdle = 1'b0,
    StMul  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  wr_addr;
    logic        zero;
    logic        reg_w;
    logic        mem_w;
    logic        mem_r;
    logic        mem_to_reg;
  } ex_mem_t;

  function automatic logic is_mul_funct(input logic [5:0] funct);
    return (funct == FN_MULT) || (funct == FN_MULTU);
  endfunction

endpackage

// File: rtl/ex_stage_mdu_if.sv
// ID/EX input bundle and EX/MEM output bundle of the execute stage.
// master = pipeline side driving ID/EX, slave = the execute stage.
interface ex_stage_mdu_if;
  logic [31:0] rs_data_in;
  logic [31:0] rt_data_in;
  logic [31:0] imm_in;
  logic [1:0]  alu_op_in;
  logic [5:0]  funct_in;
  logic [4:0]  shamt_in;
  logic [4:0]  rd_addr_in;
  logic [4:0]  rt_addr_in;
  logic        alu_src_in;
  logic        reg_w_in;
  logic        reg_dst_in;
  logic        mem_w_in;
  logic        mem_r_in;
  logic        mem_to_reg_in;

  logic        stall_out;
  logic [31:0] alu_result_out;
  logic [31:0] store_data_out;
  logic [4:0]  wr_addr_out;
  logic        zero_out;
  logic        reg_w_out;
  logic        mem_w_out;
  logic        mem_r_out;
  logic        mem_to_reg_out;

  modport master (
    output rs_data_in, rt_data_in, imm_in, alu_op_in, funct_in, shamt_in, rd_addr_in,
           rt_addr_in, alu_src_in, reg_w_in, reg_dst_in, mem_w_in, mem_r_in, mem_to_reg_in,
    input  stall_out, alu_result_out, store_data_out, wr_addr_out, zero_out, reg_w_out,
           mem_w_out, mem_r_out, mem_to_reg_out
  );

  modport slave (
    input  rs_data_in, rt_data_in, imm_in, alu_op_in, funct_in, shamt_in, rd_addr_in,
           rt_addr_in, alu_src_in, reg_w_in, reg_dst_in, mem_w_in, mem_r_in, mem_to_reg_in,
    output stall_out, alu_result_out, store_data_out, wr_addr_out, zero_out, reg_w_out,
           mem_w_out, mem_r_out, mem_to_reg_out
  );
endinterface

// File: rtl/mdu_seq_mult.sv
// Iterative shift-add multiplier with HI/LO; one iteration per falling edge.
// MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits above the LSB are zero.
module mdu_seq_mult
  import mips_pkg::*;
#(
  parameter int unsigned MUL_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CntW = $clog2(MUL_ITERS);

  mdu_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]    mcand_q, mcand_d;
  logic [31:0]    mplier_q, mplier_d;
  logic [63:0]    prod_q, prod_d;
  logic           neg_q, neg_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;

  logic [32:0]    sum;
  logic [63:0]    prod_step;
  logic [63:0]    prod_final;
  logic [63:0]    prod_signed;
  logic           last;

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Add into the upper half, then shift the whole 64-bit accumulator right by one.
  always_comb begin
    sum       = {1'b0, prod_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
    prod_step = {sum, prod_q[31:1]};
  end

`ifdef MULT_EARLY_EXIT_EN
  logic [CntW:0] shift_rem;
  // Skipped iterations still owe their right shifts; apply them in one go at the end.
  always_comb begin
    last       = (cnt_q == CntW'(MUL_ITERS - 1)) || (mplier_q[31:1] == '0);
    shift_rem  = (CntW + 1)'(MUL_ITERS - 1) - {1'b0, cnt_q};
    prod_final = prod_step >> shift_rem;
  end
`else
  always_comb begin
    last       = (cnt_q == CntW'(MUL_ITERS - 1));
    prod_final = prod_step;
  end
`endif

  assign prod_signed = neg_q ? (~prod_final + 64'd1) : prod_final;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d  = StMul;
          cnt_d    = '0;
          prod_d   = '0;
          neg_d    = is_signed && (op_a[31] ^ op_b[31]);
          mcand_d  = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
          mplier_d = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
        end
      end
      StMul: begin
        prod_d   = prod_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (last) begin
          state_d      = StIdle;
          {hi_d, lo_d} = prod_signed;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy  = (state_q == StMul);
    stall = (state_q == StIdle) ? req : !last;
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/ex_stage_mdu.sv
// MIPS execute stage: single-cycle ALU, operand muxes and EX/MEM register, plus the
// iterative multiplier (MULT_EARLY_EXIT_EN selects its early-exit variant).
module ex_stage_mdu
  import mips_pkg::*;
#(
  parameter int unsigned MUL_ITERS = 32
) (
  input logic           clk,
  input logic           rst_n,
  ex_stage_mdu_if.slave bus
);

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_req;
  logic        mul_signed;
  logic        mul_busy;
  logic        mul_stall;
  logic        bubble;
  ex_mem_t     exmem_d, exmem_q;

  assign op_a       = bus.rs_data_in;
  assign op_b       = bus.alu_src_in ? bus.imm_in : bus.rt_data_in;
  assign mul_req    = (alu_op_e'(bus.alu_op_in) == AluRtype) && is_mul_funct(bus.funct_in);
  assign mul_signed = (bus.funct_in == FN_MULT);

  mdu_seq_mult #(
    .MUL_ITERS(MUL_ITERS)
  ) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (mul_req),
    .is_signed(mul_signed),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (mul_busy),
    .stall    (mul_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(bus.alu_op_in))
      AluAdd: alu_res = op_a + op_b;
      AluSub: alu_res = op_a - op_b;
      AluRtype: begin
        case (bus.funct_in)
          FN_ADD:  alu_res = op_a + op_b;
          FN_SUB:  alu_res = op_a - op_b;
          FN_AND:  alu_res = op_a & op_b;
          FN_OR:   alu_res = op_a | op_b;
          FN_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
          FN_SLL:  alu_res = op_b << bus.shamt_in;
          FN_SRL:  alu_res = op_b >> bus.shamt_in;
          FN_MFHI: alu_res = hi;
          FN_MFLO: alu_res = lo;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // A multiply occupies EX from the issue edge through completion; emit bubbles meanwhile.
  assign bubble = mul_req || mul_busy;

  always_comb begin
    exmem_d = '0;
    if (!bubble) begin
      exmem_d.alu_result = alu_res;
      exmem_d.store_data = bus.rt_data_in;
      exmem_d.wr_addr    = bus.reg_dst_in ? bus.rd_addr_in : bus.rt_addr_in;
      exmem_d.zero       = (alu_res == '0);
      exmem_d.reg_w      = bus.reg_w_in;
      exmem_d.mem_w      = bus.mem_w_in;
      exmem_d.mem_r      = bus.mem_r_in;
      exmem_d.mem_to_reg = bus.mem_to_reg_in;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign bus.stall_out      = mul_stall;
  assign bus.alu_result_out = exmem_q.alu_result;
  assign bus.store_data_out = exmem_q.store_data;
  assign bus.wr_addr_out    = exmem_q.wr_addr;
  assign bus.zero_out       = exmem_q.zero;
  assign bus.reg_w_out      = exmem_q.reg_w;
  assign bus.mem_w_out      = exmem_q.mem_w;
  assign bus.mem_r_out      = exmem_q.mem_r;
  assign bus.mem_to_reg_out = exmem_q.mem_to_reg;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Self-checking bench for ex_stage_mdu: ALU vector table, multiply sequences, reset abort.
// Expected stall lengths follow MULT_EARLY_EXIT_EN.
module tb_ex_stage_mdu;
  import mips_pkg::*;

  logic clk = 1'b1;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_stage_mdu_if bus ();

  ex_stage_mdu #(
    .MUL_ITERS(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] a, b, imm;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh, rd, rt;
    logic        src, rdst, rw, mw, mr, m2r;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res, sd;
    logic [4:0]  wa;
    logic        zero;
    logic [3:0]  ctrl;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[14];

`ifdef MULT_EARLY_EXIT_EN
  localparam int StNeg3x5 = 3;
  localparam int StBig    = 17;
  localparam int StMaxx2  = 2;
  localparam int St5x3    = 2;
`else
  localparam int StNeg3x5 = 32;
  localparam int StBig    = 32;
  localparam int StMaxx2  = 32;
  localparam int St5x3    = 32;
`endif

  function automatic vec_t mk(input string name, input logic [31:0] a, b, imm,
                              input logic [1:0] op, input logic [5:0] fn,
                              input logic [4:0] sh, rd, rt,
                              input logic src, rdst, rw, mw, mr, m2r,
                              input logic [31:0] res, input logic z);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.imm = imm; v.op = op; v.fn = fn;
    v.sh = sh; v.rd = rd; v.rt = rt; v.src = src; v.rdst = rdst;
    v.rw = rw; v.mw = mw; v.mr = mr; v.m2r = m2r; v.exp_res = res; v.exp_zero = z;
    return v;
  endfunction

  function automatic vec_t mfx(input string name, input logic [5:0] fn, input logic [31:0] res,
                               input logic z);
    return mk(name, 32'h0, 32'h0, 32'h0, 2'b10, fn, 5'd0, 5'd8, 5'd0,
              1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, res, z);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.rs_data_in    = v.a;
    bus.rt_data_in    = v.b;
    bus.imm_in        = v.imm;
    bus.alu_op_in     = v.op;
    bus.funct_in      = v.fn;
    bus.shamt_in      = v.sh;
    bus.rd_addr_in    = v.rd;
    bus.rt_addr_in    = v.rt;
    bus.alu_src_in    = v.src;
    bus.reg_dst_in    = v.rdst;
    bus.reg_w_in      = v.rw;
    bus.mem_w_in      = v.mw;
    bus.mem_r_in      = v.mr;
    bus.mem_to_reg_in = v.m2r;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check($sformatf("%s/result", e.name), bus.alu_result_out, e.res);
    check($sformatf("%s/store_data", e.name), bus.store_data_out, e.sd);
    check($sformatf("%s/wr_addr", e.name), 32'(bus.wr_addr_out), 32'(e.wa));
    check($sformatf("%s/zero", e.name), 32'(bus.zero_out), 32'(e.zero));
    check($sformatf("%s/ctrl", e.name),
          32'({bus.reg_w_out, bus.mem_w_out, bus.mem_r_out, bus.mem_to_reg_out}),
          32'(e.ctrl));
  endtask

  // Called one time unit after a falling edge; returns at the same phase one edge later.
  task automatic step(input vec_t v);
    exp_t e;
    drive(v);
    e.name = v.name;
    e.res  = v.exp_res;
    e.sd   = v.b;
    e.wa   = v.rdst ? v.rd : v.rt;
    e.zero = v.exp_zero;
    e.ctrl = {v.rw, v.mw, v.mr, v.m2r};
    sb.push_back(e);
    @(posedge clk);
    check($sformatf("%s/stall", v.name), 32'(bus.stall_out), 32'd0);
    @(negedge clk);
    #1;
    compare_out();
  endtask

  task automatic run_mul(input string name, input logic [31:0] a, b, input logic sgn,
                         input int exp_stall);
    vec_t v;
    int   cnt;
    bit   bad;
    cnt = 0;
    bad = 1'b0;
    v = mk(name, a, b, 32'h0, 2'b10, sgn ? FN_MULT : FN_MULTU, 5'd0, 5'd1, 5'd1,
           1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(v);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (!bus.stall_out) break;
      cnt++;
      if (cnt > 1 && (bus.alu_result_out != 32'h0 || bus.reg_w_out || bus.mem_w_out)) bad = 1'b1;
    end
    @(negedge clk);
    #1;
    if (bus.alu_result_out != 32'h0 || bus.reg_w_out || bus.mem_w_out) bad = 1'b1;
    check($sformatf("%s/stall_cycles", name), 32'(cnt), 32'(exp_stall));
    check($sformatf("%s/bubble", name), 32'(bad), 32'd0);
  endtask

  initial begin
    vec_t nop;
    nop = mk("nop", 32'h0, 32'h0, 32'h0, 2'b00, 6'h0, 5'd0, 5'd0, 5'd0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    //             name        a             b             imm           op     fn      sh     rd     rt     src  rdst rw   mw   mr   m2r  res           z
    tbl[0]  = mk("slt_neg",  32'hFFFFFFFF, 32'h00000001, 32'h0,       2'b10, FN_SLT, 5'd0,  5'd3,  5'd4,  1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h00000001,1'b0);
    tbl[1]  = mk("sub_eq",   32'd7,        32'd7,        32'h0,       2'b01, 6'h0,   5'd0,  5'd6,  5'd5,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h00000000,1'b1);
    tbl[2]  = mk("addi_neg", 32'd100,      32'h00000055, 32'hFFFFFFFC,2'b00, 6'h0,   5'd0,  5'd2,  5'd9,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'd96,       1'b0);
    tbl[3]  = mk("and",      32'hF0F01234, 32'h0FF0FFFF, 32'h0,       2'b10, FN_AND, 5'd0,  5'd10, 5'd0,  1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h00F01234,1'b0);
    tbl[4]  = mk("or",       32'hF0000000, 32'h0000000F, 32'h0,       2'b10, FN_OR,  5'd0,  5'd11, 5'd0,  1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'hF000000F,1'b0);
    tbl[5]  = mk("add_wrap", 32'hFFFFFFFF, 32'h00000002, 32'h0,       2'b10, FN_ADD, 5'd0,  5'd12, 5'd0,  1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h00000001,1'b0);
    tbl[6]  = mk("sub_neg",  32'd3,        32'd5,        32'h0,       2'b10, FN_SUB, 5'd0,  5'd13, 5'd0,  1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'hFFFFFFFE,1'b0);
    tbl[7]  = mk("sll",      32'h00001234, 32'h00000001, 32'h0,       2'b10, FN_SLL, 5'd31, 5'd14, 5'd0,  1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h80000000,1'b0);
    tbl[8]  = mk("srl",      32'h0,        32'h80000000, 32'h0,       2'b10, FN_SRL, 5'd4,  5'd15, 5'd0,  1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h08000000,1'b0);
    tbl[9]  = mk("slt_pos",  32'd5,        32'hFFFFFFFE, 32'h0,       2'b10, FN_SLT, 5'd0,  5'd16, 5'd0,  1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h00000000,1'b1);
    tbl[10] = mk("rsvd_op",  32'd1,        32'd1,        32'h0,       2'b11, 6'h0,   5'd0,  5'd0,  5'd17, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h00000000,1'b1);
    tbl[11] = mk("bad_fn",   32'd1,        32'd2,        32'h0,       2'b10, 6'h3F,  5'd0,  5'd18, 5'd0,  1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,32'h00000000,1'b1);
    tbl[12] = mk("sw",       32'h00001000, 32'hDEADBEEF, 32'd8,       2'b00, 6'h0,   5'd0,  5'd0,  5'd19, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'h00001008,1'b0);
    tbl[13] = mk("src_rt",   32'd10,       32'd20,       32'd7,       2'b00, 6'h0,   5'd0,  5'd0,  5'd20, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd30,       1'b0);

    drive(nop);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset/stall", 32'(bus.stall_out), 32'd0);
    check("reset/result", bus.alu_result_out, 32'h0);
    check("reset/zero", 32'(bus.zero_out), 32'd0);
    check("reset/ctrl", 32'({bus.reg_w_out, bus.mem_w_out, bus.mem_r_out, bus.mem_to_reg_out}),
          32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) step(tbl[i]);

    run_mul("mult_n3x5", 32'hFFFFFFFD, 32'd5, 1'b1, StNeg3x5);
    step(mfx("mflo_n3x5", FN_MFLO, 32'hFFFFFFF1, 1'b0));
    step(mfx("mfhi_n3x5", FN_MFHI, 32'hFFFFFFFF, 1'b0));

    // Back-to-back multiplies; the second one's result must win.
    run_mul("multu_big", 32'h00010000, 32'h00010000, 1'b0, StBig);
    run_mul("multu_max", 32'hFFFFFFFF, 32'd2, 1'b0, StMaxx2);
    step(mfx("mflo_max", FN_MFLO, 32'hFFFFFFFE, 1'b0));
    step(mfx("mfhi_max", FN_MFHI, 32'h00000001, 1'b0));

    run_mul("multu_5x3", 32'd5, 32'd3, 1'b0, St5x3);
    step(mfx("mflo_5x3", FN_MFLO, 32'd15, 1'b0));
    step(mfx("mfhi_5x3", FN_MFHI, 32'd0, 1'b1));

    // Establish nonzero HI/LO, then abort a multiply with reset.
    run_mul("mult_seed", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, StMaxx2);
    step(mfx("mflo_seed", FN_MFLO, 32'd2, 1'b0));
    drive(mk("mult_abort", 32'd7, 32'd9, 32'h0, 2'b10, FN_MULT, 5'd0, 5'd1, 5'd1,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    drive(nop);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    check("abort/stall", 32'(bus.stall_out), 32'd0);
    check("abort/result", bus.alu_result_out, 32'h0);
    check("abort/wr_addr", 32'(bus.wr_addr_out), 32'd0);
    check("abort/ctrl", 32'({bus.reg_w_out, bus.mem_w_out, bus.mem_r_out, bus.mem_to_reg_out}),
          32'd0);
    step(mfx("mfhi_abort", FN_MFHI, 32'd0, 1'b1));
    step(mfx("mflo_abort", FN_MFLO, 32'd0, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_mdu.md
Name: ex_stage_mdu

Overview:
- Execute stage that consumes the ID/EX pipeline-register bundle and produces the registered EX/MEM bundle.
- Performs single-cycle ALU operations.
- Also contains an iterative 32-cycle shift-add multiplier with HI/LO registers; stalls the upstream pipeline while a multiply runs.
- Sits between the ID/EX register and the MEM stage of the 5-stage MIPS pipeline.

Parameters:
- MUL_ITERS, 32, number of shift-add iterations per multiply (equals the data width).

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, matching the pipeline registers
- rst_n  in  1  synchronous active-low reset
- rs_data_in  in  32  operand A
- rt_data_in  in  32  operand B / store data
- imm_in  in  32  sign-extended immediate
- alu_op_in  in  2  00 add, 01 sub, 10 R-type (decode funct), 11 reserved
- funct_in  in  6  R-type function field
- shamt_in  in  5  shift amount
- rd_addr_in  in  5  rd field
- rt_addr_in  in  5  rt field
- alu_src_in  in  1  1 selects imm_in as operand B
- reg_w_in, reg_dst_in, mem_w_in, mem_r_in, mem_to_reg_in  in  1 each  control bits
- stall_out  out  1  combinational; upstream holds PC, IF/ID and ID/EX while high
- alu_result_out  out  32  EX/MEM ALU result
- store_data_out  out  32  EX/MEM rt_data passthrough
- wr_addr_out  out  5  EX/MEM destination register
- zero_out  out  1  registered (ALU result == 0)
- reg_w_out, mem_w_out, mem_r_out, mem_to_reg_out  out  1 each  EX/MEM control bits

Behaviour:
- Reset: while rst_n=0 at a falling edge, every registered output, HI, LO, the counter and the FSM clear to 0/IDLE. Reset mid-multiply aborts it: HI/LO = 0, stall_out = 0 from the next cycle.
- Operand B = alu_src_in ? imm_in : rt_data_in.
- wr_addr = reg_dst_in ? rd_addr_in : rt_addr_in.
- ALU ops:
  - alu_op 00: A+B.
  - alu_op 01: A-B.
  - alu_op 11: result 0.
  - alu_op 10, by funct: 0x20 add; 0x22 sub; 0x24 and; 0x25 or; 0x2A slt (signed, result 0/1); 0x00 sll B by shamt; 0x02 srl B by shamt; 0x10 mfhi; 0x12 mflo; 0x18 mult; 0x19 multu. Any other funct gives result 0 with control bits passed through.
  - All arithmetic is 32-bit and wraps; no overflow trap.
- Latency: non-multiply instructions appear on the EX/MEM outputs one falling edge after they are presented.
- FSM states: IDLE, MUL.
- IDLE with mult/multu presented:
  - stall_out = 1 combinationally.
  - At the edge: latch |A| and |B| (mult) or raw operands (multu), record the result sign (sign A XOR sign B, mult only), clear the product accumulator and count, enter MUL.
  - EX/MEM outputs a bubble: reg_w, mem_w, mem_r and mem_to_reg = 0; result 0.
- MUL:
  - Each edge performs one iteration: if the multiplier LSB is 1, add the multiplicand into the upper half of the 64-bit accumulator; shift right; count+1.
  - Inputs are ignored; EX/MEM outputs a bubble every cycle.
  - stall_out = 1 while count < MUL_ITERS-1.
  - On the last iteration stall_out = 0, so the ID/EX register advances at that same edge. That edge also writes {HI,LO} (two's-complement negated if the sign flag is set) and the FSM returns to IDLE.
- Timing: stall_out is high for exactly 32 cycles per multiply; the instruction occupies EX for 33 edges.
- mfhi/mflo immediately after a mult reads the new HI/LO (written on the same edge the next instruction enters EX).
- Back-to-back mult: the second mult starts from IDLE on the cycle after completion.
- HI/LO change only on multiply completion or reset.

Optional Feature:
- Macro MULT_EARLY_EXIT_EN.
- When defined: the last iteration also occurs when the remaining multiplier bits above the LSB are all zero. stall_out drops that cycle; the result is identical.
- When undefined: every multiply takes exactly MUL_ITERS iterations.

Decomposition:
- Shared package mips_pkg holds the alu_op encodings, funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, FN_MFHI, FN_MFLO, FN_MULT, FN_MULTU) and an FSM state typedef.
- One natural sub-module: mdu_seq_mult, containing the iterative multiplier, counter and HI/LO. ex_stage_mdu holds the ALU, muxes and EX/MEM register.

Test Plan:
- Reset: rst_n=0 mid-multiply, then rst_n=1 → all outputs 0, stall_out=0; mfhi returns 0.
- ALU: alu_op=10, funct 0x2A, A=-1, B=1 → result 1, zero 0. Then alu_op=01, A=B=7 → result 0, zero_out=1 one edge later.
- I-type: alu_src=1, imm=-4, A=100, reg_dst=0, rt=9 → result 96, wr_addr_out=9.
- mult: A=-3, B=5 → stall_out high for 32 cycles, bubbles on EX/MEM; following mflo gives 0xFFFFFFF1, mfhi gives 0xFFFFFFFF.
- multu: A=0xFFFFFFFF, B=2 → HI=1, LO=0xFFFFFFFE. A back-to-back second multu also gets 32 stall cycles.
- With MULT_EARLY_EXIT_EN: multu A=5, B=3 → stall_out high 2 cycles, LO=15; without the macro, 32 cycles.
